leaf_switch: RTL and testbench
==============================

LEAF_SWITCH -- requirements
Module: leaf_switch

Interface
REQ-001 Parameters SHALL be: GROUP_ID, default 3, 4-bit group served by this switch; DATA_W, default 16, flit width; FIFO_DEPTH, default 2, per-input buffer entries.
REQ-002 Port clk SHALL be: input, 1 bit, single clock, all state updates on its rising edge.
REQ-003 Port reset_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port leaf_data_in SHALL be: input, 4*DATA_W bits, flit from NI k in slice [k*DATA_W +: DATA_W].
REQ-005 Port leaf_valid_in SHALL be: input, 4 bits, per-NI flit valid.
REQ-006 Port leaf_ready_out SHALL be: output, 4 bits, per-NI input buffer not full.
REQ-007 Port leaf_data_out SHALL be: output, 4*DATA_W bits, flit to NI k.
REQ-008 Port leaf_valid_out SHALL be: output, 4 bits, one-cycle valid pulse to NI k; no backpressure.
REQ-009 Port up_data_in SHALL be: input, DATA_W bits, flit from the uplink.
REQ-010 Port up_valid_in SHALL be: input, 1 bit, uplink flit valid.
REQ-011 Port up_ready_out SHALL be: output, 1 bit, uplink input buffer not full.
REQ-012 Port up_data_out SHALL be: output, DATA_W bits, flit toward the uplink.
REQ-013 Port up_valid_out SHALL be: output, 1 bit, uplink output valid.
REQ-014 Port up_ready_in SHALL be: input, 1 bit, uplink accepts the flit.
REQ-015 Port drop_count SHALL be: output, 8 bits, dropped-flit counter.

Function
REQ-016 Header decode SHALL use flit bits [15:12] as group and [11:10] as leaf; payload [9:0] and header SHALL pass unmodified.
REQ-017 Routing SHALL be: group==GROUP_ID -> leaf output [11:10]; group!=GROUP_ID and group!=0 -> uplink output; group==0 -> drop.
REQ-018 An uplink-input flit with group!=GROUP_ID SHALL be dropped, never reflected back to the uplink.
REQ-019 Each of the 5 inputs SHALL own a FIFO_DEPTH-entry FIFO; push on valid&&ready; ready SHALL equal (count<FIFO_DEPTH), derived from registered count only.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 Each output SHALL have a round-robin arbiter over the 5 FIFO heads (order leaf0..leaf3, up); the last granted input SHALL become lowest priority.
REQ-022 Leaf outputs SHALL grant every cycle a head targets them; the registered leaf_valid_out SHALL pulse exactly one cycle per flit.
REQ-023 The uplink output SHALL hold up_data_out/up_valid_out stable while up_valid_out && !up_ready_in; a new grant SHALL occur only when the output register is empty or being accepted.
REQ-024 A FIFO head SHALL pop only in the cycle it is granted (or dropped); a head blocked on the uplink SHALL not block other inputs' heads.
REQ-025 Latency SHALL be 1 cycle: a flit pushed at edge N with an idle target appears on the output after edge N+1.
REQ-026 Drops SHALL pop the head in one cycle without asserting any output valid.

Reset
REQ-027 On reset_n low, all FIFO counts/pointers, arbiter pointers (to leaf0), *_valid_out, *_data_out and drop_count SHALL clear to 0 immediately, including mid-transfer; buffered flits are discarded.
REQ-028 leaf_ready_out and up_ready_out SHALL read 1 as soon as reset clears the counts.

Configuration
REQ-029 With LEAF_SW_STATS_EN defined, drop_count SHALL increment by one per dropped flit, saturating at 255, counting multiple simultaneous drops in a cycle.
REQ-030 Without LEAF_SW_STATS_EN, drop_count SHALL be constant 0 and no counter logic SHALL exist; drop behaviour is unchanged.

Verification
REQ-031 Leaf0 sends 0x3A55 (group 3, leaf 2) -> leaf_valid_out[2] pulses once one cycle later, leaf_data_out slice 2 = 0x3A55.
REQ-032 Leaf0..leaf3 simultaneously send flits to leaf 1 -> four outputs on consecutive cycles in order 0,1,2,3; no flit lost.
REQ-033 Leaf1 sends 0x5123 with up_ready_in=0 for 4 cycles -> up_valid_out=1 and up_data_out=0x5123 held stable, accepted on the cycle up_ready_in rises; leaf1 stalls after FIFO_DEPTH further flits (leaf_ready_out[1]=0).
REQ-034 Uplink sends 0x7000 and leaf2 sends 0x0000 -> no valid out; drop_count=2 with LEAF_SW_STATS_EN, 0 without.
REQ-035 Two flits buffered, reset_n pulsed low mid-stream -> all valids 0 immediately, ready_out all 1 after release, no stale flit emitted.

Source files
------------

// File: rtl/leaf_switch.sv
// rtl/leaf_switch.sv - 5-port leaf switch (4 NIs + uplink) with per-input FIFOs and round-robin outputs.
// Optional dropped-flit statistics counter is built when LEAF_SW_STATS_EN is defined.
module leaf_switch #(
    parameter logic [3:0] GROUP_ID   = 4'd3,
    parameter int         DATA_W     = 16,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4*DATA_W-1:0] leaf_data_in,
    input  logic [3:0]          leaf_valid_in,
    output logic [3:0]          leaf_ready_out,
    output logic [4*DATA_W-1:0] leaf_data_out,
    output logic [3:0]          leaf_valid_out,
    input  logic [DATA_W-1:0]   up_data_in,
    input  logic                up_valid_in,
    output logic                up_ready_out,
    output logic [DATA_W-1:0]   up_data_out,
    output logic                up_valid_out,
    input  logic                up_ready_in,
    output logic [7:0]          drop_count
);

    localparam int NIN   = 5;
    localparam int UP    = 4;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0] TGT_DROP = 3'd5;

    logic [DATA_W-1:0] mem_q    [NIN][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NIN];
    logic [PTR_W-1:0]  wr_ptr_d [NIN];
    logic [PTR_W-1:0]  rd_ptr_q [NIN];
    logic [PTR_W-1:0]  rd_ptr_d [NIN];
    logic [CNT_W-1:0]  cnt_q    [NIN];
    logic [CNT_W-1:0]  cnt_d    [NIN];
    logic [2:0]        rr_ptr_q [NIN];
    logic [2:0]        rr_ptr_d [NIN];

    logic [DATA_W-1:0] in_data  [NIN];
    logic [DATA_W-1:0] head     [NIN];
    logic [2:0]        tgt      [NIN];
    logic [NIN-1:0]    req      [NIN];
    logic [2:0]        gnt_idx  [NIN];
    logic [NIN-1:0]    in_valid;
    logic [NIN-1:0]    in_ready;
    logic [NIN-1:0]    push;
    logic [NIN-1:0]    pop;
    logic [NIN-1:0]    head_vld;
    logic [NIN-1:0]    drop;
    logic [NIN-1:0]    served;
    logic [NIN-1:0]    gnt_vld;
    logic              up_load_ok;

    logic [3:0]          leaf_valid_q, leaf_valid_d;
    logic [4*DATA_W-1:0] leaf_data_q,  leaf_data_d;
    logic                up_valid_q,   up_valid_d;
    logic [DATA_W-1:0]   up_data_q,    up_data_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Returns {found, index}; search starts at p, so the input after the last winner has top priority.
    function automatic logic [3:0] rr_pick(input logic [NIN-1:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [3:0] s;
        res = '0;
        for (int k = NIN - 1; k >= 0; k--) begin
            s = {1'b0, p} + 4'(k);
            if (s >= 4'(NIN)) s = s - 4'(NIN);
            if (r[s[2:0]]) res = {1'b1, s[2:0]};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = leaf_valid_in[i];
            in_data[i]  = leaf_data_in[i*DATA_W +: DATA_W];
        end
        in_valid[UP] = up_valid_in;
        in_data[UP]  = up_data_in;
    end

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            in_ready[i] = (cnt_q[i] < CNT_W'(FIFO_DEPTH));
            push[i]     = in_valid[i] && in_ready[i];
            head_vld[i] = (cnt_q[i] != '0);
            head[i]     = mem_q[i][rd_ptr_q[i]];
        end
    end

    assign leaf_ready_out = in_ready[3:0];
    assign up_ready_out   = in_ready[UP];

    // Uplink-sourced flits may only go down to a leaf; anything else from the uplink is dropped.
    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            tgt[i] = TGT_DROP;
            if (head[i][15:12] == GROUP_ID)
                tgt[i] = {1'b0, head[i][11:10]};
            else if (head[i][15:12] != 4'd0 && i != UP)
                tgt[i] = 3'd4;
            drop[i] = head_vld[i] && (tgt[i] == TGT_DROP);
        end
    end

    assign up_load_ok = !up_valid_q || up_ready_in;

    always_comb begin
        logic [3:0] pick;
        served = '0;
        for (int o = 0; o < NIN; o++) begin
            for (int i = 0; i < NIN; i++)
                req[o][i] = head_vld[i] && (tgt[i] == 3'(o));
            if (o == UP && !up_load_ok)
                req[o] = '0;
            pick       = rr_pick(req[o], rr_ptr_q[o]);
            gnt_vld[o] = pick[3];
            gnt_idx[o] = pick[2:0];
            rr_ptr_d[o] = rr_ptr_q[o];
            if (pick[3]) begin
                served[pick[2:0]] = 1'b1;
                rr_ptr_d[o] = (pick[2:0] == 3'(UP)) ? 3'd0 : pick[2:0] + 3'd1;
            end
        end
        pop = served | drop;
    end

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (push[i] && !pop[i])
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (!push[i] && pop[i])
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
    end

    always_comb begin
        leaf_valid_d = '0;
        leaf_data_d  = leaf_data_q;
        for (int o = 0; o < 4; o++) begin
            leaf_valid_d[o] = gnt_vld[o];
            if (gnt_vld[o])
                leaf_data_d[o*DATA_W +: DATA_W] = head[gnt_idx[o]];
        end
        up_valid_d = up_valid_q;
        up_data_d  = up_data_q;
        if (up_load_ok) begin
            up_valid_d = gnt_vld[UP];
            if (gnt_vld[UP])
                up_data_d = head[gnt_idx[UP]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                rr_ptr_q[i] <= '0;
            end
            leaf_valid_q <= '0;
            leaf_data_q  <= '0;
            up_valid_q   <= 1'b0;
            up_data_q    <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i]    <= cnt_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                rr_ptr_q[i] <= rr_ptr_d[i];
            end
            leaf_valid_q <= leaf_valid_d;
            leaf_data_q  <= leaf_data_d;
            up_valid_q   <= up_valid_d;
            up_data_q    <= up_data_d;
        end
    end

    // Storage needs no reset: entries are only visible through the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NIN; i++)
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i];
    end

    assign leaf_valid_out = leaf_valid_q;
    assign leaf_data_out  = leaf_data_q;
    assign up_valid_out   = up_valid_q;
    assign up_data_out    = up_data_q;

`ifdef LEAF_SW_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        logic [8:0] sum;
        sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NIN; i++)
            sum = sum + {8'd0, drop[i]};
        drop_cnt_d = (sum > 9'd255) ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_leaf_switch.sv
// tb/tb_leaf_switch.sv - self-checking bench for leaf_switch: vector table, corner sequences, random scoreboard.
module tb_leaf_switch;

    localparam int DW    = 16;
    localparam int DEPTH = 2;
`ifdef LEAF_SW_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4*DW-1:0] leaf_data_in;
    logic [3:0]    leaf_valid_in;
    logic [3:0]    leaf_ready_out;
    logic [4*DW-1:0] leaf_data_out;
    logic [3:0]    leaf_valid_out;
    logic [DW-1:0] up_data_in;
    logic          up_valid_in;
    logic          up_ready_out;
    logic [DW-1:0] up_data_out;
    logic          up_valid_out;
    logic          up_ready_in;
    logic [7:0]    drop_count;

    always #5 clk = ~clk;

    leaf_switch dut (
        .clk(clk), .reset_n(reset_n),
        .leaf_data_in(leaf_data_in), .leaf_valid_in(leaf_valid_in), .leaf_ready_out(leaf_ready_out),
        .leaf_data_out(leaf_data_out), .leaf_valid_out(leaf_valid_out),
        .up_data_in(up_data_in), .up_valid_in(up_valid_in), .up_ready_out(up_ready_out),
        .up_data_out(up_data_out), .up_valid_out(up_valid_out), .up_ready_in(up_ready_in),
        .drop_count(drop_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]      lv;
        logic [4*DW-1:0] ld;
        logic            uv;
        logic [DW-1:0]   ud;
        logic [3:0]      elv;
        logic [4*DW-1:0] eld;
        logic            euv;
        logic [DW-1:0]   eud;
        logic [7:0]      edrop;
    } vec_t;

    vec_t vecs [8];
    logic [15:0] expq [25][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        leaf_valid_in = '0;
        leaf_data_in  = '0;
        up_valid_in   = 1'b0;
        up_data_in    = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        up_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();
    endtask

    // Destination by routing rules: 0..3 leaf, 4 uplink, 5 drop.
    function automatic int route(input int src, input logic [15:0] f);
        if (f[15:12] == 4'd3) return int'(f[11:10]);
        if (f[15:12] == 4'd0) return 5;
        if (src == 4) return 5;
        return 4;
    endfunction

    function automatic logic [15:0] gen_flit(input int src, input int seq);
        logic [3:0] g;
        int r;
        r = $urandom_range(0, 3);
        if (r == 0)      g = 4'd0;
        else if (r < 3)  g = 4'd3;
        else begin
            g = 4'($urandom_range(1, 15));
            if (g == 4'd3) g = 4'd4;
        end
        return {g, 2'($urandom_range(0, 3)), 3'(src), 7'(seq)};
    endfunction

    initial begin
        int acc;
        logic pushed;
        int drops;
        int seq [5];
        logic prev_uv, prev_ur;
        logic [15:0] prev_ud, f;
        int left;

        vecs[0] = '{4'b0001, {48'h0, 16'h3A55}, 1'b0, 16'h0, 4'b0100, {16'h0, 16'h3A55, 32'h0}, 1'b0, 16'h0, 8'd0};
        vecs[1] = '{4'b1000, {16'h3000, 48'h0}, 1'b0, 16'h0, 4'b0001, {48'h0, 16'h3000}, 1'b0, 16'h0, 8'd0};
        vecs[2] = '{4'b0100, {16'h0, 16'h5123, 32'h0}, 1'b0, 16'h0, 4'b0000, 64'h0, 1'b1, 16'h5123, 8'd0};
        vecs[3] = '{4'b0000, 64'h0, 1'b1, 16'h3C01, 4'b1000, {16'h3C01, 48'h0}, 1'b0, 16'h0, 8'd0};
        vecs[4] = '{4'b0000, 64'h0, 1'b1, 16'h7000, 4'b0000, 64'h0, 1'b0, 16'h0, 8'd1};
        vecs[5] = '{4'b0001, 64'h0, 1'b0, 16'h0, 4'b0000, 64'h0, 1'b0, 16'h0, 8'd1};
        vecs[6] = '{4'b0011, {32'h0, 16'h3800, 16'h3400}, 1'b1, 16'h3123, 4'b0111,
                    {16'h0, 16'h3800, 16'h3400, 16'h3123}, 1'b0, 16'h0, 8'd0};
        vecs[7] = '{4'b1010, {16'h0ABC, 16'h0, 16'hF3FF, 16'h0}, 1'b1, 16'h3FFF, 4'b1000,
                    {16'h3FFF, 48'h0}, 1'b1, 16'hF3FF, 8'd1};

        // Reset state
        reset_n = 1'b0;
        idle_inputs();
        up_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_leaf_valid", leaf_valid_out, 0);
        chk("rst_up_valid", up_valid_out, 0);
        chk("rst_leaf_data", leaf_data_out, 0);
        chk("rst_up_data", up_data_out, 0);
        chk("rst_leaf_ready", leaf_ready_out, 4'hF);
        chk("rst_up_ready", up_ready_out, 1);
        chk("rst_drop", drop_count, 0);
        reset_n = 1'b1;
        step();

        // Four leaves to leaf1 together: served 0,1,2,3 from a fresh arbiter
        leaf_valid_in = 4'hF;
        leaf_data_in  = {16'h3413, 16'h3412, 16'h3411, 16'h3410};
        step();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr_valid_%0d", k), leaf_valid_out, 4'b0010);
            chk($sformatf("rr_data_%0d", k), leaf_data_out[31:16], 16'h3410 + 16'(k));
        end
        step();
        chk("rr_done", leaf_valid_out, 0);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            logic [7:0] d0;
            d0 = drop_count;
            leaf_valid_in = vecs[v].lv;
            leaf_data_in  = vecs[v].ld;
            up_valid_in   = vecs[v].uv;
            up_data_in    = vecs[v].ud;
            step();
            idle_inputs();
            step();
            chk($sformatf("vec%0d_leaf_valid", v), leaf_valid_out, vecs[v].elv);
            for (int k = 0; k < 4; k++)
                if (vecs[v].elv[k])
                    chk($sformatf("vec%0d_leaf%0d_data", v, k), leaf_data_out[k*DW +: DW], vecs[v].eld[k*DW +: DW]);
            chk($sformatf("vec%0d_up_valid", v), up_valid_out, vecs[v].euv);
            if (vecs[v].euv)
                chk($sformatf("vec%0d_up_data", v), up_data_out, vecs[v].eud);
            step();
            chk($sformatf("vec%0d_pulse_end", v), {leaf_valid_out, up_valid_out}, 0);
            chk($sformatf("vec%0d_drops", v), drop_count - d0, (STATS != 0) ? vecs[v].edrop : 8'd0);
        end

        // Uplink backpressure hold and leaf1 stall
        do_reset();
        up_ready_in = 1'b0;
        leaf_valid_in = 4'b0010;
        leaf_data_in[31:16] = 16'h5123;
        step();
        leaf_data_in[31:16] = 16'h5124;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            pushed = leaf_ready_out[1];
            step();
            if (pushed) begin
                acc++;
                leaf_data_in[31:16] = 16'h5124 + 16'(acc);
            end
            chk($sformatf("hold_valid_%0d", i), up_valid_out, 1);
            chk($sformatf("hold_data_%0d", i), up_data_out, 16'h5123);
        end
        chk("stall_accepted", acc, DEPTH);
        chk("stall_ready", leaf_ready_out[1], 0);
        idle_inputs();
        up_ready_in = 1'b1;
        step();
        chk("bp_next_valid", up_valid_out, 1);
        chk("bp_next_data", up_data_out, 16'h5124);
        step();
        chk("bp_last_data", up_data_out, 16'h5125);
        step();
        chk("bp_drained", up_valid_out, 0);

        // Simultaneous drops from uplink and leaf2
        do_reset();
        up_valid_in = 1'b1;
        up_data_in  = 16'h7000;
        leaf_valid_in = 4'b0100;
        leaf_data_in  = 64'h0;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("drop_novalid_%0d", i), {leaf_valid_out, up_valid_out}, 0);
        end
        chk("drop_count_2", drop_count, (STATS != 0) ? 8'd2 : 8'd0);

        // Reset mid-stream
        do_reset();
        up_ready_in = 1'b0;
        leaf_valid_in = 4'b0001;
        leaf_data_in[15:0] = 16'h5001;
        step();
        leaf_data_in[15:0] = 16'h5002;
        step();
        leaf_data_in[15:0] = 16'h5003;
        step();
        idle_inputs();
        chk("mid_pre_valid", up_valid_out, 1);
        chk("mid_pre_ready", leaf_ready_out[0], 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_up_valid", up_valid_out, 0);
        chk("mid_rst_leaf_valid", leaf_valid_out, 0);
        chk("mid_rst_up_data", up_data_out, 0);
        chk("mid_rst_ready", {leaf_ready_out, up_ready_out}, 5'h1F);
        @(posedge clk);
        #1 reset_n = 1'b1;
        up_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("mid_nostale_%0d", i), {leaf_valid_out, up_valid_out}, 0);
        end
        chk("mid_post_ready", {leaf_ready_out, up_ready_out}, 5'h1F);

        // Randomized traffic against a queue scoreboard
        do_reset();
        drops = 0;
        for (int s = 0; s < 5; s++) seq[s] = 0;
        prev_uv = 1'b0;
        prev_ur = 1'b1;
        prev_ud = '0;
        for (int cyc = 0; cyc < 3040; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if (leaf_valid_out[k]) begin
                    int q;
                    logic hit;
                    f = leaf_data_out[k*DW +: DW];
                    q = int'(f[9:7]) * 5 + k;
                    hit = (f[9:7] <= 3'd4) && (expq[q].size() > 0);
                    chk("rand_leaf_expected", hit, 1);
                    if (hit) chk("rand_leaf_data", f, expq[q].pop_front());
                end
            end
            if (prev_uv && !prev_ur) begin
                chk("rand_up_hold_valid", up_valid_out, 1);
                chk("rand_up_hold_data", up_data_out, prev_ud);
            end
            up_ready_in = (cyc >= 3000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (up_valid_out && up_ready_in) begin
                int q;
                logic hit;
                f = up_data_out;
                q = int'(f[9:7]) * 5 + 4;
                hit = (f[9:7] <= 3'd4) && (expq[q].size() > 0);
                chk("rand_up_expected", hit, 1);
                if (hit) chk("rand_up_data", f, expq[q].pop_front());
            end
            prev_uv = up_valid_out;
            prev_ur = up_ready_in;
            prev_ud = up_data_out;

            idle_inputs();
            if (cyc < 3000) begin
                for (int s = 0; s < 4; s++) begin
                    leaf_valid_in[s] = 1'($urandom_range(0, 1));
                    leaf_data_in[s*DW +: DW] = gen_flit(s, seq[s]);
                end
                up_valid_in = 1'($urandom_range(0, 1));
                up_data_in  = gen_flit(4, seq[4]);
            end
            for (int s = 0; s < 5; s++) begin
                logic v, r;
                int d;
                v = (s == 4) ? up_valid_in : leaf_valid_in[s];
                r = (s == 4) ? up_ready_out : leaf_ready_out[s];
                f = (s == 4) ? up_data_in : leaf_data_in[s*DW +: DW];
                if (v && r) begin
                    seq[s]++;
                    d = route(s, f);
                    if (d == 5) drops++;
                    else expq[s*5 + d].push_back(f);
                end
            end
            step();
        end
        left = 0;
        for (int q = 0; q < 25; q++) left += expq[q].size();
        chk("rand_all_delivered", left, 0);
        chk("rand_drop_count", drop_count, (STATS != 0) ? ((drops > 255) ? 255 : drops) : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
